// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the instruction memory.
//
// Accepts a byte stream on a valid/ready handshake. It packs every four bytes
// into a little-endian 32-bit word and writes each word to consecutive word
// addresses starting at BASE_ADDR. The CPU is held (cpu_hold=1) until the
// requested number of words has been written.
//
// Ports
//   CLK        clock, all state changes on the rising edge
//   RST        asynchronous reset, active low
//   start      load request pulse, sampled only in IDLE or DONE
//   num_words  number of words to load, captured when start is accepted
//   in_valid   byte stream valid
//   in_data    byte stream data
//   in_ready   loader takes a byte this cycle when in_valid is also high
//   mem_we     instruction memory write enable, one pulse per word
//   mem_addr   byte address of the write (BASE_ADDR + 4*index)
//   mem_wd     assembled write data, held between writes
//   cpu_hold   1 = keep the CPU stalled
//   done       load completed
//   err        last start was rejected (num_words > DEPTH_WORDS)
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          DEPTH_WORDS = 256,
  parameter int          CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wd,
  output logic             cpu_hold,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state;
  logic [1:0]       byte_cnt;
  logic [CNT_W-1:0] word_idx;
  logic [CNT_W-1:0] word_total;
  logic [23:0]      word_buf;

  logic             armed;
  logic             start_zero;
  logic             start_big;
  logic             accept_load;
  logic             hs;
  logic [CNT_W:0]   next_idx;
  logic [31:0]      word_off;

  // One extra bit so the count comparison is exact for any CNT_W up to 32.
  assign armed       = start && ((state == S_IDLE) || (state == S_DONE));
  assign start_zero  = (num_words == '0);
  assign start_big   = (33'(num_words) > 33'(DEPTH_WORDS));
  assign accept_load = armed && !start_big && !start_zero;
  assign hs          = (state == S_RECV) && in_valid && in_ready;
  assign next_idx    = {1'b0, word_idx} + (CNT_W+1)'(1);
  assign word_off    = 32'(word_idx) << 2;

  // Control state and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      byte_cnt <= 2'd0;
      word_idx <= '0;
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= BASE_ADDR;
      mem_wd   <= 32'h0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (armed) begin
            if (start_big) begin
              // Rejected: remain in the current state, only flag the error.
              err <= 1'b1;
            end else if (start_zero) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              err      <= 1'b0;
            end else begin
              state    <= S_RECV;
              word_idx <= '0;
              byte_cnt <= 2'd0;
              err      <= 1'b0;
              done     <= 1'b0;
              cpu_hold <= 1'b1;
              in_ready <= 1'b1;
            end
          end
        end

        S_RECV: begin
          if (hs) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Fourth byte completes the word; present it for one write cycle.
              mem_wd   <= {in_data, word_buf};
              mem_addr <= BASE_ADDR + word_off;
              mem_we   <= 1'b1;
              in_ready <= 1'b0;
              state    <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          mem_we   <= 1'b0;
          word_idx <= next_idx[CNT_W-1:0];
          if (next_idx == {1'b0, word_total}) begin
            state    <= S_DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state    <= S_RECV;
            in_ready <= 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          mem_we   <= 1'b0;
        end
      endcase
    end
  end

  // Datapath holding registers. They are not reset: a reset mid-load drops
  // byte_cnt, so any stale partial bytes are overwritten before use.
  always_ff @(posedge CLK) begin
    if (accept_load) begin
      word_total <= num_words;
    end
    if (hs) begin
      case (byte_cnt)
        2'd0:    word_buf[7:0]   <= in_data;
        2'd1:    word_buf[15:8]  <= in_data;
        2'd2:    word_buf[23:16] <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: reset values, single and multi-word
// loads, paced input, zero/oversize requests, async reset mid-load, start
// ignored during a load, and re-arming from DONE.
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_words = 16'd0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int          wr_cnt = 0;
  int          rdy_during_we = 0;
  int          base;

  imem_loader #(
    .BASE_ADDR  (32'h0),
    .DEPTH_WORDS(256),
    .CNT_W      (16)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .num_words(num_words),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  // Log every memory write and flag in_ready overlapping a write cycle.
  always @(posedge CLK) begin
    if (mem_we) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] <= mem_addr;
        wr_data[wr_cnt] <= mem_wd;
      end
      wr_cnt <= wr_cnt + 1;
      if (in_ready) rdy_during_we <= rdy_during_we + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] n);
    start     = 1'b1;
    num_words = n;
    tick();
    start     = 1'b0;
  endtask

  // Present one byte and wait (bounded) for the handshake edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    if (!ok) chk("hs_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    if (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], gap);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we",   mem_we,   0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wd",   mem_wd,   32'h0);
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_done",     done,     0);
    chk("rst_err",      err,      0);
    RST = 1'b1;
    tick();

    // Single word 0x00500093
    base = wr_cnt;
    pulse_start(16'd1);
    chk("t2_in_ready", in_ready, 1);
    chk("t2_hold_recv", cpu_hold, 1);
    send_word(32'h00500093, 1'b0);
    chk("t2_we",       mem_we,   1);
    chk("t2_addr",     mem_addr, 32'h0);
    chk("t2_wd",       mem_wd,   32'h00500093);
    chk("t2_rdy_wr",   in_ready, 0);
    tick();
    chk("t2_done",     done,     1);
    chk("t2_hold",     cpu_hold, 0);
    chk("t2_we_off",   mem_we,   0);
    chk("t2_wd_hold",  mem_wd,   32'h00500093);
    chk("t2_nwr",      wr_cnt - base, 1);
    chk("t2_log_addr", wr_addr[base], 32'h0);
    chk("t2_log_data", wr_data[base], 32'h00500093);

    // Async reset mid-RECV after two bytes
    base = wr_cnt;
    pulse_start(16'd1);
    chk("t1_hold_rearm", cpu_hold, 1);
    chk("t1_done_rearm", done, 0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    chk("t1_rdy",  in_ready, 0);
    chk("t1_we",   mem_we,   0);
    chk("t1_addr", mem_addr, 32'h0);
    chk("t1_wd",   mem_wd,   32'h0);
    chk("t1_hold", cpu_hold, 1);
    chk("t1_done", done,     0);
    chk("t1_err",  err,      0);
    tick();
    tick();
    RST = 1'b1;
    tick();
    chk("t1_nwr_rst", wr_cnt - base, 0);
    pulse_start(16'd1);
    send_word(32'hA5A55A5A, 1'b0);
    tick();
    chk("t1_done2",  done, 1);
    chk("t1_nwr",    wr_cnt - base, 1);
    chk("t1_waddr",  wr_addr[base], 32'h0);
    chk("t1_wdata",  wr_data[base], 32'hA5A55A5A);

    // Oversize and zero-length requests from IDLE
    RST = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    base = wr_cnt;
    pulse_start(16'd257);
    chk("t4_err",  err,      1);
    chk("t4_rdy",  in_ready, 0);
    chk("t4_hold", cpu_hold, 1);
    chk("t4_done", done,     0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    in_valid = 1'b0;
    chk("t4_stay_rdy",  in_ready, 0);
    chk("t4_stay_hold", cpu_hold, 1);
    pulse_start(16'd0);
    chk("t4z_done", done,     1);
    chk("t4z_hold", cpu_hold, 0);
    tick();
    chk("t4z_nwr", wr_cnt - base, 0);

    // Three words with in_valid toggled every other cycle
    base = wr_cnt;
    pulse_start(16'd3);
    chk("t3_hold", cpu_hold, 1);
    chk("t3_done", done,     0);
    send_word(32'h11223344, 1'b1);
    send_word(32'hDEADBEEF, 1'b1);
    send_word(32'h00000013, 1'b1);
    chk("t3_fin",  done, 1);
    chk("t3_nwr",  wr_cnt - base, 3);
    chk("t3_a0",   wr_addr[base],   32'h0);
    chk("t3_d0",   wr_data[base],   32'h11223344);
    chk("t3_a1",   wr_addr[base+1], 32'h4);
    chk("t3_d1",   wr_data[base+1], 32'hDEADBEEF);
    chk("t3_a2",   wr_addr[base+2], 32'h8);
    chk("t3_d2",   wr_data[base+2], 32'h00000013);

    // start pulsed mid-load is ignored; re-arm from DONE with two words
    base = wr_cnt;
    pulse_start(16'd2);
    chk("t5_hold", cpu_hold, 1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    pulse_start(16'd5);
    chk("t5_ign_rdy", in_ready, 1);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    send_word(32'hCAFEF00D, 1'b0);
    chk("t5_we2",   mem_we,   1);
    chk("t5_addr2", mem_addr, 32'h4);
    tick();
    chk("t5_done",  done,     1);
    chk("t5_hold2", cpu_hold, 0);
    repeat (3) tick();
    chk("t5_nwr", wr_cnt - base, 2);
    chk("t5_a0",  wr_addr[base],   32'h0);
    chk("t5_d0",  wr_data[base],   32'h04030201);
    chk("t5_a1",  wr_addr[base+1], 32'h4);
    chk("t5_d1",  wr_data[base+1], 32'hCAFEF00D);

    chk("rdy_during_we", rdy_during_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
